// File: rtl/my_fifo_buffer.sv
// my_fifo_buffer: single-clock FIFO on a registered dual-port RAM with occupancy and sticky error flags.
// Define MY_FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads are standard two-edge latency.
module my_fifo_buffer #(
    parameter int AW           = 10,
    parameter int DW           = 64,
    parameter int AFULL_THRESH = (1 << AW) - 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    output logic          full,
    output logic          almost_full,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] AFULL = (AW+1)'(AFULL_THRESH);

    logic [DW-1:0] r_mem [2**AW];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [AW:0]   w_count_nxt;
    logic [DW-1:0] r_ram_q;
    logic [DW-1:0] r_rd_data;
    logic          r_rd_valid;
    logic          r_full;
    logic          r_afull;
    logic          r_ovf;
    logic          r_unf;
    logic          w_push;
    logic          w_pop;
    logic          w_fetch;
    logic          w_empty;

    assign w_push = wr_en && !r_full;
    assign w_pop  = rd_en && !w_empty;

    always_comb begin
        // NOTE: default assigned first so every path drives w_count_nxt and no latch is inferred.
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + (AW+1)'(1);
            2'b01:   w_count_nxt = r_count - (AW+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // NOTE: storage has no reset; only locations already written are ever fetched.
    always_ff @(posedge clk) begin
        if (w_push)  r_mem[r_wptr] <= wr_data;
        if (w_fetch) r_ram_q <= r_mem[r_rptr];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_afull <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (w_push)  r_wptr <= r_wptr + AW'(1);
            if (w_fetch) r_rptr <= r_rptr + AW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == DEPTH);
            r_afull <= (w_count_nxt >= AFULL);
            if (wr_en && r_full)  r_ovf <= 1'b1;
            if (rd_en && w_empty) r_unf <= 1'b1;
        end
    end

`ifdef MY_FIFO_FWFT_EN
    // Two-stage prefetch: RAM read register (stage 1) feeding the output register.
    logic        r_s1_valid;
    logic [AW:0] w_ram_cnt;
    logic        w_s1_adv;

    assign w_empty   = !r_rd_valid;
    assign w_ram_cnt = r_count - {{AW{1'b0}}, r_s1_valid} - {{AW{1'b0}}, r_rd_valid};
    assign w_s1_adv  = r_s1_valid && (!r_rd_valid || w_pop);
    assign w_fetch   = (w_ram_cnt != '0) && (!r_s1_valid || w_s1_adv);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            if (w_fetch)       r_s1_valid <= 1'b1;
            else if (w_s1_adv) r_s1_valid <= 1'b0;
            if (w_s1_adv) begin
                r_rd_valid <= 1'b1;
                r_rd_data  <= r_ram_q;
            end else if (w_pop) begin
                r_rd_valid <= 1'b0;
            end
        end
    end
`else
    logic r_empty;
    logic r_pop_d;

    assign w_empty = r_empty;
    assign w_fetch = w_pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_empty    <= 1'b1;
            r_pop_d    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_empty    <= (w_count_nxt == '0);
            r_pop_d    <= w_pop;
            r_rd_valid <= r_pop_d;
            if (r_pop_d) r_rd_data <= r_ram_q;
        end
    end
`endif

    assign full        = r_full;
    assign almost_full = r_afull;
    assign empty       = w_empty;
    assign count       = r_count;
    assign rd_data     = r_rd_data;
    assign rd_valid    = r_rd_valid;
    assign overflow    = r_ovf;
    assign underflow   = r_unf;

endmodule

// File: tb/tb_my_fifo_buffer.sv
// Self-checking bench for my_fifo_buffer (AW=4, DW=16, threshold 8); a queue model supplies expected values.
// Build with MY_FIFO_FWFT_EN defined to exercise the first-word-fall-through variant instead.
module tb_my_fifo_buffer;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int THR   = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic          full;
    logic          almost_full;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    my_fifo_buffer #(
        .AW(AW),
        .DW(DW),
        .AFULL_THRESH(THR)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .full(full),
        .almost_full(almost_full),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .empty(empty),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

`ifndef MY_FIFO_FWFT_EN
    logic [DW-1:0] m_q[$];
    logic          m_ovf;
    logic          m_unf;
    logic          m_pend;
    logic [DW-1:0] m_pdata;
    logic [DW-1:0] m_last;

    task automatic model_reset();
        m_q.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_pend  = 1'b0;
        m_pdata = '0;
        m_last  = '0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"},     64'(count),       64'(m_q.size()));
        check({tag, ".empty"},     64'(empty),       64'(m_q.size() == 0));
        check({tag, ".full"},      64'(full),        64'(m_q.size() == DEPTH));
        check({tag, ".afull"},     64'(almost_full), 64'(m_q.size() >= THR));
        check({tag, ".overflow"},  64'(overflow),    64'(m_ovf));
        check({tag, ".underflow"}, 64'(underflow),   64'(m_unf));
        check({tag, ".rd_valid"},  64'(rd_valid),    64'(m_pend));
        check({tag, ".rd_data"},   64'(rd_data),     64'(m_last));
    endtask

    // One clock: drive at the falling edge, update the model, sample 1 ns after the rising edge.
    task automatic step(input logic we, input logic [DW-1:0] wd, input logic re, input string tag);
        logic          push_ok;
        logic          pop_ok;
        logic [DW-1:0] popped;
        @(negedge clk);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        push_ok = we && (m_q.size() < DEPTH);
        pop_ok  = re && (m_q.size() > 0);
        popped  = '0;
        if (we && !push_ok) m_ovf = 1'b1;
        if (re && !pop_ok)  m_unf = 1'b1;
        if (pop_ok)  popped = m_q.pop_front();
        if (push_ok) m_q.push_back(wd);
        @(posedge clk);
        #1;
        if (m_pend) m_last = m_pdata;
        check_all(tag);
        m_pend  = pop_ok;
        m_pdata = popped;
    endtask
`endif

    initial begin
`ifndef MY_FIFO_FWFT_EN
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i), 1'b0, "fill");
        step(1'b1, 16'hDEAD, 1'b0, "ovf_push");
        step(1'b1, 16'hBEEF, 1'b1, "full_both");
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, '0, 1'b1, "drain");
        step(1'b0, '0, 1'b0, "drain_tail");
        step(1'b1, 16'h1234, 1'b1, "empty_both");

        for (int i = 0; i < 40; i++) step(1'b1, 16'h0100 + DW'(i), 1'b1, "wrap");
        step(1'b0, '0, 1'b1, "wrap_drain");
        step(1'b0, '0, 1'b0, "wrap_tail");

        for (int i = 0; i < 5; i++) step(1'b1, 16'h0500 + DW'(i), 1'b0, "c5_fill");
        for (int i = 0; i < 4; i++) step(1'b1, 16'h0550 + DW'(i), 1'b1, "c5_both");
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, "c5_drain");
        step(1'b0, '0, 1'b0, "c5_tail");

        for (int i = 0; i < 7; i++) step(1'b1, 16'h0700 + DW'(i), 1'b0, "pre_rst");
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all("mid_rst");
        wr_en   = 1'b1;
        wr_data = 16'h0077;
        m_q.push_back(16'h0077);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("first_push");
        step(1'b0, '0, 1'b1, "pop_new");
        step(1'b0, '0, 1'b0, "rd_new");
        step(1'b0, '0, 1'b0, "idle_end");
`else
        repeat (3) @(posedge clk);
        #1;
        check("reset.rd_valid", 64'(rd_valid), 64'd0);
        check("reset.empty",    64'(empty),    64'd1);
        check("reset.count",    64'(count),    64'd0);
        check("reset.rd_data",  64'(rd_data),  64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = 16'h00A5;
        @(posedge clk);
        #1;
        check("n0.count",    64'(count),    64'd1);
        check("n0.rd_valid", 64'(rd_valid), 64'd0);
        check("n0.empty",    64'(empty),    64'd1);
        @(negedge clk);
        wr_en = 1'b0;
        @(posedge clk);
        #1;
        check("n1.rd_valid", 64'(rd_valid), 64'd0);
        @(posedge clk);
        #1;
        check("n2.rd_valid", 64'(rd_valid), 64'd1);
        check("n2.rd_data",  64'(rd_data),  64'h00A5);
        check("n2.empty",    64'(empty),    64'd0);
        check("n2.count",    64'(count),    64'd1);
        @(negedge clk);
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        check("ack.rd_valid", 64'(rd_valid), 64'd0);
        check("ack.count",    64'(count),    64'd0);

        @(negedge clk);
        rd_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr_en   = 1'b1;
            wr_data = 16'h0010 + DW'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        // Each falling edge must present the next word: no bubble across the burst.
        for (int i = 0; i < 10; i++) begin
            check("burst.rd_valid", 64'(rd_valid), 64'd1);
            check("burst.rd_data",  64'(rd_data),  64'h0010 + 64'(i));
            rd_en = 1'b1;
            @(negedge clk);
        end
        check("post.rd_valid",  64'(rd_valid),  64'd0);
        check("post.count",     64'(count),     64'd0);
        check("post.underflow", 64'(underflow), 64'd0);
        @(negedge clk);
        rd_en = 1'b0;
        check("unf.underflow", 64'(underflow), 64'd1);
        check("unf.overflow",  64'(overflow),  64'd0);
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
